// File: rtl/ins_fetch.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction memory and
// registers each returned word, with its PC, into a valid/ready slot for the decoder.
module ins_fetch #(
  parameter int unsigned  AW         = 4,
  parameter int unsigned  DW         = 8,
  parameter logic [DW-1:0] HALT_INSTR = 8'h00
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  output logic [AW-1:0] fetch_addr_o,
  input  logic [DW-1:0] fetch_data_i,
  input  logic          jump_valid_i,
  input  logic [AW-1:0] jump_addr_i,
  output logic          instr_valid_o,
  input  logic          instr_ready_i,
  output logic [DW-1:0] instr_out_o,
  output logic [AW-1:0] instr_pc_o,
  output logic          halted_o
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] ipc_q, ipc_d;
  logic          slot_free;

  assign slot_free = !valid_q || instr_ready_i;

  // Next-state: jump beats capture/stall; capture only in RUN with a free slot.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      StIdle: begin
        if (jump_valid_i) begin
          pc_d    = jump_addr_i;
          state_d = StRun;
        end else if (start_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (jump_valid_i) begin
          pc_d    = jump_addr_i;
          valid_d = 1'b0;
        end else if (slot_free) begin
          valid_d = 1'b1;
          instr_d = fetch_data_i;
          ipc_d   = pc_q;
          // A halt opcode is still presented, but the PC stays on it.
          if (fetch_data_i == HALT_INSTR) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      StHalt: begin
        if (jump_valid_i) begin
          pc_d    = jump_addr_i;
          valid_d = 1'b0;
          state_d = StRun;
        end else if (valid_q && instr_ready_i) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and slot registers, asynchronously cleared by reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign fetch_addr_o  = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_out_o   = instr_q;
  assign instr_pc_o    = ipc_q;
  assign halted_o      = (state_q == StHalt);

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed scenarios with literal expectations plus a randomized run,
// all cross-checked every cycle against a behavioural model of the fetch slot.
module tb_ins_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       jump_valid = 1'b0;
  logic [3:0] jump_addr = '0;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_out;
  logic [3:0] instr_pc;
  logic       halted;

  logic [7:0] mem [16];
  int checks = 0;
  int errors = 0;

  assign fetch_data = mem[fetch_addr];

  ins_fetch dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .fetch_addr_o (fetch_addr),
    .fetch_data_i (fetch_data),
    .jump_valid_i (jump_valid),
    .jump_addr_i  (jump_addr),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instr_out_o  (instr_out),
    .instr_pc_o   (instr_pc),
    .halted_o     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 halted; slot = (valid, word, pc).
  int         m_mode;
  int         m_pc;
  bit         m_valid;
  logic [7:0] m_word;
  int         m_wpc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_pc = 0; m_valid = 0; m_word = 0; m_wpc = 0;
    end else if (jump_valid) begin
      m_pc = jump_addr; m_valid = 0; m_mode = 1;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!m_valid || instr_ready) begin
        m_valid = 1; m_word = mem[m_pc]; m_wpc = m_pc;
        if (m_word == 8'h00) m_mode = 2;
        else m_pc = (m_pc + 1) % 16;
      end
    end else begin
      if (m_valid && instr_ready) m_valid = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("m_fetch_addr", 32'(fetch_addr), 32'(m_pc));
      check("m_valid", 32'(instr_valid), 32'(m_valid));
      check("m_halted", 32'(halted), 32'(m_mode == 2));
      if (m_valid) begin
        check("m_instr_out", 32'(instr_out), 32'(m_word));
        check("m_instr_pc", 32'(instr_pc), 32'(m_wpc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_out", 32'(instr_out), 0);
    check("rst_pc", 32'(instr_pc), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fetch_addr", 32'(fetch_addr), 0);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic jump(input logic [3:0] a);
    jump_valid = 1'b1; jump_addr = a;
    step();
    jump_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    do_reset();

    // 1: streaming from pc 0 with no gaps
    instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_idle_to_run_valid", 32'(instr_valid), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t1_pc", 32'(instr_pc), 32'(k));
      check("t1_out", 32'(instr_out), 32'(8'h10 + 8'(k)));
    end

    // 2: stall three cycles holding pc 5
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_stall_pc", 32'(instr_pc), 5);
      check("t2_stall_out", 32'(instr_out), 8'h15);
      check("t2_stall_fetch", 32'(fetch_addr), 6);
    end
    instr_ready = 1'b1;
    step();
    check("t2_resume_pc", 32'(instr_pc), 6);

    // 3: wrap from 14
    jump(4'd14);
    check("t3_flush", 32'(instr_valid), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_wrap_pc", 32'((14 + k) % 16), 32'(instr_pc));
    end

    // 4: halt at 5, then jump to 9
    mem[5] = 8'h00;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("t4_halt_pc", 32'(instr_pc), 5);
    check("t4_halt_out", 32'(instr_out), 0);
    check("t4_halt_valid", 32'(instr_valid), 1);
    check("t4_halted", 32'(halted), 1);
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      step();
      check("t4_no_capture", 32'(instr_valid), 0);
      check("t4_hold_fetch", 32'(fetch_addr), 5);
    end
    start = 1'b0;
    jump(4'd9);
    check("t4_unhalt", 32'(halted), 0);
    step();
    check("t4_jump_pc", 32'(instr_pc), 9);
    mem[5] = 8'h15;

    // 5: jump while stalled on pc 7
    jump(4'd7);
    step();
    check("t5_hold7", 32'(instr_pc), 7);
    instr_ready = 1'b0;
    jump(4'd3);
    check("t5_dropped", 32'(instr_valid), 0);
    instr_ready = 1'b1;
    step();
    check("t5_pc3", 32'(instr_pc), 3);

    // 6: reset mid-stream, refetch requires start
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_idle_valid", 32'(instr_valid), 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t6_refetch_pc", 32'(instr_pc), 0);
    check("t6_refetch_valid", 32'(instr_valid), 1);

    // Randomized run, checked by the model every cycle
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start       = ($urandom_range(0, 3) == 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      jump_valid  = ($urandom_range(0, 15) == 0);
      jump_addr   = 4'($urandom_range(0, 15));
      step();
      if (c % 500 == 499)
        for (int i = 0; i < 16; i++)
          mem[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    end
    jump_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
